// File: rtl/datapath_sequencer_if.sv
// Instruction channel into the datapath sequencer: one packed 26-bit word per valid/ready transfer.
// master drives instr/instr_valid, slave returns instr_ready.
interface datapath_sequencer_if;
    logic [25:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Turns LOADI/ALU/NOP/HALT instructions into register-file/ALU control with a SETTLE-cycle setup before each write.
// Latency: write strobe SETTLE+1 cycles after accept; stalls input (instr_ready=0) while a write is in flight or after HALT.
module datapath_sequencer #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    datapath_sequencer_if.slave  instr_bus,
    output logic                 writeEnable,
    output logic                 muxSel,
    output logic [7:0]           inputData,
    output logic [3:0]           dstSel,
    output logic [3:0]           A_sel,
    output logic [3:0]           B_sel,
    output logic [3:0]           OP_Sel,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal_op,
    output logic [CNT_W-1:0]     retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SETUP = 2'b01,
        S_WRITE = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_LOADI = 2'b01;
    localparam logic [1:0] CMD_ALU   = 2'b10;
    localparam logic [1:0] CMD_HALT  = 2'b11;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  settle_cnt;
    logic [3:0]  settle_cnt_nxt;
    logic        ready_q;

    logic [1:0]  f_cmd;
    logic [3:0]  f_op;
    logic [3:0]  f_dst;
    logic [3:0]  f_a;
    logic [3:0]  f_b;
    logic [7:0]  f_imm;

    logic        accept;
    logic        op_legal;
    logic        latch_loadi;
    logic        latch_alu;
    logic        count_en;
    logic        flag_illegal;

    assign f_cmd = instr_bus.instr[25:24];
    assign f_op  = instr_bus.instr[23:20];
    assign f_dst = instr_bus.instr[19:16];
    assign f_a   = instr_bus.instr[15:12];
    assign f_b   = instr_bus.instr[11:8];
    assign f_imm = instr_bus.instr[7:0];

    assign instr_bus.instr_ready = ready_q;

    // Handshake uses the registered ready, so the first cycle out of reset never accepts.
    assign accept = (state == S_IDLE) && ready_q && instr_bus.instr_valid;

    always_comb begin
        op_legal = 1'b0;
        case (f_op)
            4'b0000, 4'b0100, 4'b0101, 4'b0110,
            4'b0111, 4'b1000, 4'b1001: op_legal = 1'b1;
            default:                   op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        latch_loadi    = 1'b0;
        latch_alu      = 1'b0;
        count_en       = 1'b0;
        flag_illegal   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (f_cmd)
                        CMD_NOP: begin
                            count_en = 1'b1;
                        end
                        CMD_HALT: begin
                            count_en  = 1'b1;
                            state_nxt = S_HALT;
                        end
                        CMD_LOADI: begin
                            latch_loadi    = 1'b1;
                            settle_cnt_nxt = SETTLE_LAST;
                            state_nxt      = S_SETUP;
                        end
                        CMD_ALU: begin
                            if (op_legal) begin
                                latch_alu      = 1'b1;
                                settle_cnt_nxt = SETTLE_LAST;
                                state_nxt      = S_SETUP;
                            end else begin
                                flag_illegal = 1'b1;
                                count_en     = 1'b1;
                            end
                        end
                        default: begin
                            state_nxt = S_IDLE;
                        end
                    endcase
                end
            end
            S_SETUP: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = S_WRITE;
                end else begin
                    settle_cnt_nxt = settle_cnt - 4'd1;
                end
            end
            S_WRITE: begin
                count_en  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the next-state decode so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            settle_cnt  <= 4'd0;
            ready_q     <= 1'b0;
            writeEnable <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            illegal_op  <= 1'b0;
            retired     <= '0;
        end else begin
            state       <= state_nxt;
            settle_cnt  <= settle_cnt_nxt;
            ready_q     <= (state_nxt == S_IDLE);
            writeEnable <= (state_nxt == S_WRITE);
            busy        <= (state_nxt == S_SETUP) || (state_nxt == S_WRITE);
            halted      <= halted || (state_nxt == S_HALT);
            illegal_op  <= illegal_op || flag_illegal;
            if (count_en && (retired != CNT_MAX)) begin
                retired <= retired + CNT_ONE;
            end
        end
    end

    // Selects only change on an accepted LOADI/ALU; unused fields keep their old values.
    always_ff @(posedge clk) begin
        if (reset) begin
            muxSel    <= 1'b0;
            inputData <= 8'd0;
            dstSel    <= 4'd0;
            A_sel     <= 4'd0;
            B_sel     <= 4'd0;
            OP_Sel    <= 4'd0;
        end else if (latch_loadi) begin
            muxSel    <= 1'b1;
            inputData <= f_imm;
            dstSel    <= f_dst;
        end else if (latch_alu) begin
            muxSel    <= 1'b0;
            OP_Sel    <= f_op;
            A_sel     <= f_a;
            B_sel     <= f_b;
            dstSel    <= f_dst;
        end
    end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Instruction-driven control stage sitting directly upstream of the 16×8 register-file/ALU `datapath`. It accepts one packed 26-bit instruction at a time over a valid/ready handshake and produces that stage's control ports (`writeEnable`, `muxSel`, `inputData`, `dstSel`, `A_sel`, `B_sel`, `OP_Sel`) with correct setup/write sequencing. It also counts retired instructions, flags illegal ALU opcodes and supports a terminal HALT, so programs run without hand-timed stimulus.

## Interface
- `SETTLE`, 1: cycles selects are held with `writeEnable`=0 before the write cycle (legal 1..15).
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `instr` in 26: [25:24] cmd (00 NOP, 01 LOADI, 10 ALU, 11 HALT), [23:20] op, [19:16] dst, [15:12] a, [11:8] b, [7:0] imm.
- `instr_valid` in 1: `instr` is presented.
- `instr_ready` out 1: sequencer accepts `instr` this cycle.
- `writeEnable` out 1: datapath register write strobe.
- `muxSel` out 1: 1 = write `inputData`, 0 = write ALU result.
- `inputData` out 8: immediate for LOADI.
- `dstSel`, `A_sel`, `B_sel`, `OP_Sel` out 4 each: datapath selects.
- `busy` out 1: instruction in flight (SETUP or WRITE).
- `halted` out 1: HALT retired; sticky until reset.
- `illegal_op` out 1: sticky; an ALU instruction carried an unsupported op.
- `retired` out CNT_W: count of instructions completed (NOP, LOADI, ALU, HALT).

## Operation
- States: IDLE, SETUP, WRITE, HALT.
- IDLE: `instr_ready`=1. Transfer on `instr_valid && instr_ready` at a rising edge.
  - NOP: stay IDLE, `retired`+1.
  - HALT: go HALT, `halted`=1, `retired`+1.
  - LOADI: latch `muxSel`=1, `inputData`=imm, `dstSel`=dst; go SETUP.
  - ALU, legal op ∈ {0000 zero, 0100 add, 0101 negate A, 0110 and, 0111 or, 1000 eq, 1001 gt}: latch `muxSel`=0, `OP_Sel`=op, `A_sel`=a, `B_sel`=b, `dstSel`=dst; go SETUP.
  - ALU, any other op: no register write, `illegal_op`=1, `retired`+1, stay IDLE; outputs unchanged.
- SETUP: `instr_ready`=0, `writeEnable`=0; internal counter runs SETTLE cycles, then WRITE.
- WRITE: `writeEnable`=1 for exactly one cycle, then IDLE, `retired`+1 on that exit edge.
- HALT: `instr_ready`=0, `writeEnable`=0, absorbing until `reset`.
- Fields not used by the cmd (e.g. `inputData` for ALU, `A_sel` for LOADI) keep their previous values.
- All selects remain stable from SETUP entry through the WRITE cycle and are held afterwards in IDLE until the next accepted LOADI/ALU.
- `retired` saturates at all-ones, no wrap.

## Timing
- All outputs registered. Reset values: `instr_ready`=0 while `reset` high, 1 the first cycle after; every other output 0; state IDLE.
- LOADI/ALU: accept edge T → SETUP T..T+SETTLE → `writeEnable` high during cycle T+SETTLE; datapath captures at end of that cycle; `instr_ready` high again from T+SETTLE+1. Throughput: one write per SETTLE+2 cycles.
- NOP / illegal ALU: `instr_ready` stays 1; back-to-back acceptance every cycle.
- `instr` is sampled only at the accept edge; changes while not ready are ignored.
- `reset` in SETUP or WRITE aborts: `writeEnable` 0 from the next edge, no write, `retired` not incremented, sticky flags cleared.
- `instr_valid` while HALT: ignored, no count change.

## Test plan
- LOADI dst=0 imm=2, then dst=1 imm=4 (SETTLE=1): `writeEnable` high exactly one cycle each, 3 cycles apart; datapath regs[0]=2, regs[1]=4; `retired`=2.
- ALU add op=0100 a=0 b=1 dst=15 after the loads above: `muxSel`=0 and selects stable for SETUP+WRITE; regs[15]=6.
- ALU op=0011, then NOP, streamed back-to-back: `illegal_op`=1, no `writeEnable` pulse, `instr_ready` held 1, `retired`+2 across two cycles.
- SETTLE=3, LOADI dst=4 imm=8'hAA: `writeEnable` asserts on the 4th cycle after accept; regs[4]=8'hAA; `instr_ready` low for 4 cycles.
- Assert `reset` during SETUP of LOADI dst=5 imm=8'hCC: no write to regs[5], all outputs 0, `retired`=0, accepts again the cycle after reset releases.
- HALT followed by valid LOADI: `halted`=1, `instr_ready`=0, no `writeEnable`; `retired` unchanged after HALT's increment.
